johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
- Receive-side counterpart of the team's 4-bit Johnson (twisted-ring) counter.
- Samples a Johnson-coded word each valid cycle and decodes it to a binary phase index.
- Flags illegal code words, and tracks lock to the expected ring sequence with sequence-error detection and an error counter.
- Sits downstream of any Johnson counter or sequencer whose state must be consumed as binary or monitored for upsets.

Parameters:
- WIDTH, 4: Johnson word width. Ring length is 2*WIDTH states. Legal range is 2..16.
- LOCK_COUNT, 3: number of consecutive legal in-sequence codes needed to declare lock. Legal range is 1..15.
- ALLOW_HOLD, 1: when 1, a repeated code (source not advancing) is in-sequence. When 0, every valid code must advance by exactly one.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low.
- code_in  input  WIDTH  Johnson word; bit 0 is the stage fed by the inverted MSB.
- code_valid  input  1  qualifies code_in this cycle.
- clear_err  input  1  synchronous clear of err_cnt.
- count_out  output  IDXW=$clog2(2*WIDTH)  decoded phase index 0..2*WIDTH-1.
- count_valid  output  1  count_out valid (one-cycle pulse per accepted legal code).
- code_err  output  1  one-cycle pulse: sampled code was illegal.
- seq_err  output  1  one-cycle pulse: legal code, not in sequence, while locked.
- locked  output  1  tracker is in LOCKED.
- err_cnt  output  8  saturating count of code_err + seq_err events.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All outputs go to 0 and the FSM goes to UNLOCKED.
  - The internal lock counter, prev_idx and prev_ok are cleared.
  - Reset has priority over every other input, including mid-lock.
- Ring order for WIDTH=4 (index 0..7): 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then wraps to 0000.
- Legality: code_in has at most one position i (0..WIDTH-2) where code_in[i] != code_in[i+1]. Examples: 0101 and 1001 are illegal.
- Decode (combinational, then registered):
  - p = popcount(code_in).
  - idx = p if code_in[WIDTH-1]==0, else 2*WIDTH - p.
  - Checks: 1111 -> 4; 1000 -> 7; 0000 -> 0.
- Latency:
  - All outputs are registered and respond exactly 1 cycle after the code_valid sample.
  - When code_valid==0: count_valid, code_err and seq_err are 0 next cycle; count_out, locked and state hold.
- Successor rule: in-sequence means idx == (prev_idx+1) mod 2*WIDTH, or idx == prev_idx when ALLOW_HOLD==1. Wrap 2*WIDTH-1 -> 0 is in-sequence.
- FSM states: UNLOCKED, LOCKED. State is updated only on code_valid cycles.
- UNLOCKED:
  - Illegal code: code_err=1, lock counter cleared, prev_ok=0.
  - Legal code with prev_ok==0: seed prev_idx, lock counter=1, count_valid=1.
  - Legal code, in-sequence: lock counter increments; when it reaches LOCK_COUNT, go to LOCKED (locked=1 on the same output edge as that code's count_valid).
  - Legal code, out-of-sequence: reseed prev_idx, lock counter=1, no seq_err.
  - With LOCK_COUNT==1, the first legal code locks.
- LOCKED:
  - Legal and in-sequence: count_valid=1, prev_idx updated.
  - Legal, out-of-sequence: count_valid=1, seq_err=1, go to UNLOCKED, reseed prev_idx, lock counter=1.
  - Illegal: code_err=1, count_valid=0, go to UNLOCKED, prev_ok=0.
- count_out updates only when count_valid is asserted. On an illegal code it holds its last legal value.
- err_cnt:
  - Increments by 1 per cycle where code_err or seq_err is asserted (they are mutually exclusive).
  - Saturates at 255.
  - clear_err forces it to 0; if clear_err coincides with an error event, the result is 0 (clear wins).

Decomposition:
- Shared package johnson_pkg holds:
  - the state enum (UNLOCKED, LOCKED);
  - the ring-length function 2*WIDTH;
  - an IDXW helper;
  - the errcnt width constant (8).
- One sub-module, johnson_code_check: combinational legality check plus popcount index decode (WIDTH parameter; outputs legal, idx).
- Tracker FSM, lock counter, error counter and output registers stay in the top module.

Test Plan:
- Reset, then drive the full WIDTH=4 ring 0000..1000..0000 on consecutive valid cycles:
  - count_out = 0,1,...,7,0, each one cycle later;
  - locked rises with the 3rd code;
  - no errors.
- While locked, inject 0101:
  - code_err pulse, count_valid=0, locked falls next cycle, err_cnt=1, count_out holds.
- While locked at idx 2 (0011), send 1111 (idx 4):
  - seq_err pulse, count_valid=1 with count_out=4, locked falls;
  - then 1110, 1100 relock with locked=1 on 1100.
- ALLOW_HOLD=1: send 0111 twice while locked -> no error, count_out=3 twice. With ALLOW_HOLD=0 the same stimulus gives seq_err.
- Force 300 illegal codes:
  - err_cnt saturates at 255;
  - clear_err asserted in the same cycle as an error -> err_cnt=0.
- Assert reset low for one cycle while locked mid-sequence:
  - all outputs 0 next cycle;
  - relock requires 3 fresh in-sequence codes;
  - code_valid low cycles in between must not advance state.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and sizing helpers for the Johnson-code decoder.
package johnson_pkg;

  // Lock tracker states.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  // Width of the saturating error counter.
  localparam int ERRCNT_W = 8;

  // Number of distinct states in a Johnson ring of the given word width.
  function automatic int ring_len(input int width);
    return 2 * width;
  endfunction

  // Bits needed to hold a phase index 0..ring_len-1.
  function automatic int idx_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decoder_code_check.sv
// Combinational legality check and phase-index decode of one Johnson word.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDXW  = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] code_in,
  output logic             legal,
  output logic [IDXW-1:0]  idx
);

  // Legal words have at most one boundary between a run of ones and a run of zeros;
  // the index is the number of ones, mirrored once the MSB has filled.
  always_comb begin
    int edges;
    int ones;
    edges = 0;
    ones  = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (code_in[i] != code_in[i+1]) edges++;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (code_in[i]) ones++;
    end
    legal = (edges <= 1);
    if (code_in[WIDTH-1]) idx = IDXW'(ring_len(WIDTH) - ones);
    else                  idx = IDXW'(ones);
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes phase index, flags illegal words and
// tracks lock to the ring sequence with a saturating error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter  int WIDTH      = 4,
  parameter  int LOCK_COUNT = 3,
  parameter  bit ALLOW_HOLD = 1'b1,
  localparam int IDXW       = idx_w(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    code_in,
  input  logic                code_valid,
  input  logic                clear_err,
  output logic [IDXW-1:0]     count_out,
  output logic                count_valid,
  output logic                code_err,
  output logic                seq_err,
  output logic                locked,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(ring_len(WIDTH) - 1);
  localparam logic [3:0]          LOCK_TGT = 4'(LOCK_COUNT);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = '1;

  logic                legal;
  logic [IDXW-1:0]     idx;

  state_e              state_q, state_d;
  logic [3:0]          lock_cnt_q, lock_cnt_d;
  logic [IDXW-1:0]     prev_idx_q, prev_idx_d;
  logic                prev_ok_q, prev_ok_d;
  logic [IDXW-1:0]     count_out_q, count_out_d;
  logic                count_valid_q, count_valid_d;
  logic                code_err_q, code_err_d;
  logic                seq_err_q, seq_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDXW-1:0]     succ_idx;
  logic                in_seq;
  logic [4:0]          lock_inc;

  johnson_code_check #(.WIDTH(WIDTH)) u_check (
    .code_in (code_in),
    .legal   (legal),
    .idx     (idx)
  );

  // Successor test against the last accepted index, including ring wrap and optional hold.
  always_comb begin
    succ_idx = (prev_idx_q == LAST_IDX) ? '0 : prev_idx_q + 1'b1;
    in_seq   = prev_ok_q && ((idx == succ_idx) || (ALLOW_HOLD && (idx == prev_idx_q)));
    lock_inc = {1'b0, lock_cnt_q} + 5'd1;
  end

  // Next-state for the lock tracker, decoded outputs and error counter.
  always_comb begin
    state_d       = state_q;
    lock_cnt_d    = lock_cnt_q;
    prev_idx_d    = prev_idx_q;
    prev_ok_d     = prev_ok_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    code_err_d    = 1'b0;
    seq_err_d     = 1'b0;

    if (code_valid) begin
      if (!legal) begin
        code_err_d = 1'b1;
        lock_cnt_d = '0;
        prev_ok_d  = 1'b0;
        state_d    = UNLOCKED;
      end else begin
        count_valid_d = 1'b1;
        count_out_d   = idx;
        prev_idx_d    = idx;
        prev_ok_d     = 1'b1;
        case (state_q)
          UNLOCKED: begin
            if (in_seq) begin
              lock_cnt_d = lock_inc[3:0];
              if (lock_inc >= {1'b0, LOCK_TGT}) state_d = LOCKED;
            end else begin
              // Fresh seed: a single code already satisfies a lock count of one.
              lock_cnt_d = 4'd1;
              if (LOCK_TGT <= 4'd1) state_d = LOCKED;
            end
          end
          LOCKED: begin
            if (!in_seq) begin
              seq_err_d  = 1'b1;
              lock_cnt_d = 4'd1;
              state_d    = UNLOCKED;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end

    // Clear wins over a coincident error event.
    err_cnt_d = err_cnt_q;
    if (clear_err)                                            err_cnt_d = '0;
    else if ((code_err_d || seq_err_d) && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= UNLOCKED;
      lock_cnt_q    <= '0;
      prev_idx_q    <= '0;
      prev_ok_q     <= 1'b0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      prev_idx_q    <= prev_idx_d;
      prev_ok_q     <= prev_ok_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      code_err_q    <= code_err_d;
      seq_err_q     <= seq_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign code_err    = code_err_q;
  assign seq_err     = seq_err_q;
  assign locked      = (state_q == LOCKED);
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: one instance with hold allowed, one without,
// both fed the same stimulus; expectations queued at drive time, checked one cycle later.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] code_in;
  logic       code_valid;
  logic       clear_err;

  logic [2:0] count_out,   nh_count_out;
  logic       count_valid, nh_count_valid;
  logic       code_err,    nh_code_err;
  logic       seq_err,     nh_seq_err;
  logic       locked,      nh_locked;
  logic [7:0] err_cnt,     nh_err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       cv;
    logic [2:0] co;
    logic       ce;
    logic       se;
    logic       lk;
    logic [7:0] ec;
    logic       nse;
    logic       nlk;
  } exp_t;

  exp_t sb[$];

  logic [3:0] ring [8];

  always #5 clk = ~clk;

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(3), .ALLOW_HOLD(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .clear_err   (clear_err),
    .count_out   (count_out),
    .count_valid (count_valid),
    .code_err    (code_err),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  johnson_decoder #(.WIDTH(4), .LOCK_COUNT(3), .ALLOW_HOLD(1'b0)) dut_nh (
    .clk         (clk),
    .reset       (reset),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .clear_err   (clear_err),
    .count_out   (nh_count_out),
    .count_valid (nh_count_valid),
    .code_err    (nh_code_err),
    .seq_err     (nh_seq_err),
    .locked      (nh_locked),
    .err_cnt     (nh_err_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic v, input logic clr, input logic rs,
                      input logic ecv, input logic [2:0] eco, input logic ece, input logic ese,
                      input logic elk, input logic [7:0] eec, input logic ense, input logic enlk);
    exp_t e;
    code_in    = c;
    code_valid = v;
    clear_err  = clr;
    reset      = rs;
    e = '{cv: ecv, co: eco, ce: ece, se: ese, lk: elk, ec: eec, nse: ense, nlk: enlk};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count_valid", {7'd0, count_valid}, {7'd0, e.cv});
    chk("count_out",   {5'd0, count_out},   {5'd0, e.co});
    chk("code_err",    {7'd0, code_err},    {7'd0, e.ce});
    chk("seq_err",     {7'd0, seq_err},     {7'd0, e.se});
    chk("locked",      {7'd0, locked},      {7'd0, e.lk});
    chk("err_cnt",     err_cnt,             e.ec);
    chk("nohold_seq_err", {7'd0, nh_seq_err}, {7'd0, e.nse});
    chk("nohold_locked",  {7'd0, nh_locked},  {7'd0, e.nlk});
  endtask

  initial begin
    ring[0] = 4'b0000; ring[1] = 4'b0001; ring[2] = 4'b0011; ring[3] = 4'b0111;
    ring[4] = 4'b1111; ring[5] = 4'b1110; ring[6] = 4'b1100; ring[7] = 4'b1000;
    code_in = '0; code_valid = 1'b0; clear_err = 1'b0; reset = 1'b0;

    // reset state
    step(4'b0000, 0, 0, 0,  0, 3'd0, 0, 0, 0, 8'd0,  0, 0);
    step(4'b0000, 0, 0, 0,  0, 3'd0, 0, 0, 0, 8'd0,  0, 0);

    // full ring plus wrap; lock on the third code
    for (int i = 0; i < 9; i++)
      step(ring[i % 8], 1, 0, 1,  1, 3'(i % 8), 0, 0, (i >= 2), 8'd0,  0, (i >= 2));

    // illegal word while locked: count_out holds 0
    step(4'b0101, 1, 0, 1,  0, 3'd0, 1, 0, 0, 8'd1,  0, 0);

    // relock at idx 2, then jump to idx 4
    step(4'b0000, 1, 0, 1,  1, 3'd0, 0, 0, 0, 8'd1,  0, 0);
    step(4'b0001, 1, 0, 1,  1, 3'd1, 0, 0, 0, 8'd1,  0, 0);
    step(4'b0011, 1, 0, 1,  1, 3'd2, 0, 0, 1, 8'd1,  0, 1);
    step(4'b1111, 1, 0, 1,  1, 3'd4, 0, 1, 0, 8'd2,  1, 0);
    step(4'b1110, 1, 0, 1,  1, 3'd5, 0, 0, 0, 8'd2,  0, 0);
    step(4'b1100, 1, 0, 1,  1, 3'd6, 0, 0, 1, 8'd2,  0, 1);

    // repeated code while locked: accepted with hold, sequence error without
    step(4'b1000, 1, 0, 1,  1, 3'd7, 0, 0, 1, 8'd2,  0, 1);
    step(4'b0000, 1, 0, 1,  1, 3'd0, 0, 0, 1, 8'd2,  0, 1);
    step(4'b0001, 1, 0, 1,  1, 3'd1, 0, 0, 1, 8'd2,  0, 1);
    step(4'b0011, 1, 0, 1,  1, 3'd2, 0, 0, 1, 8'd2,  0, 1);
    step(4'b0111, 1, 0, 1,  1, 3'd3, 0, 0, 1, 8'd2,  0, 1);
    step(4'b0111, 1, 0, 1,  1, 3'd3, 0, 0, 1, 8'd2,  1, 0);
    step(4'b1111, 1, 0, 1,  1, 3'd4, 0, 0, 1, 8'd2,  0, 0);
    step(4'b1110, 1, 0, 1,  1, 3'd5, 0, 0, 1, 8'd2,  0, 1);
    // invalid cycle carrying an illegal word changes nothing
    step(4'b0101, 0, 0, 1,  0, 3'd5, 0, 0, 1, 8'd2,  0, 1);

    // reset while locked, with a valid illegal word present: reset wins
    step(4'b0101, 1, 0, 0,  0, 3'd0, 0, 0, 0, 8'd0,  0, 0);
    step(4'b0000, 1, 0, 1,  1, 3'd0, 0, 0, 0, 8'd0,  0, 0);
    step(4'b0001, 0, 0, 1,  0, 3'd0, 0, 0, 0, 8'd0,  0, 0);
    step(4'b0001, 1, 0, 1,  1, 3'd1, 0, 0, 0, 8'd0,  0, 0);
    step(4'b0011, 0, 0, 1,  0, 3'd1, 0, 0, 0, 8'd0,  0, 0);
    step(4'b0011, 1, 0, 1,  1, 3'd2, 0, 0, 1, 8'd0,  0, 1);

    // error counter saturation
    for (int k = 1; k <= 300; k++)
      step(4'b1001, 1, 0, 1,  0, 3'd2, 1, 0, 0, (k > 255) ? 8'd255 : 8'(k),  0, 0);

    // clear coincident with an error event
    step(4'b0101, 1, 1, 1,  0, 3'd2, 1, 0, 0, 8'd0,  0, 0);
    step(4'b0000, 1, 0, 1,  1, 3'd0, 0, 0, 0, 8'd0,  0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
